// File: rtl/i2s_rx_sequencer.sv
// Master-mode I2S receiver: generates SCK/WS, deserialises left/right PCM samples and
// presents them over a valid/ready handshake with frame-aligned enable/disable.
module i2s_rx_sequencer #(
  parameter int unsigned CLK_DIV      = 32,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 24
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    enable_in,
  input  logic                    sd_in,
  output logic                    sck_out,
  output logic                    ws_out,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_right_out,
  output logic                    sample_valid_out,
  input  logic                    sample_ready_in,
  output logic                    overrun_out,
  output logic                    active_out
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned BitW = $clog2(2 * SLOT_WIDTH);

  localparam logic [DivW-1:0] RiseCnt = DivW'(CLK_DIV / 2 - 1);
  localparam logic [DivW-1:0] FallCnt = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] HalfCnt = DivW'(CLK_DIV / 2);
  localparam logic [BitW-1:0] SlotW   = BitW'(SLOT_WIDTH);
  localparam logic [BitW-1:0] SampW   = BitW'(SAMPLE_WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(2 * SLOT_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSync, StRun, StStop} state_e;

  state_e                  state_q, state_d;
  logic [DivW-1:0]         div_q, div_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic                    sck_q, sck_d;
  logic                    ws_q, ws_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    done_q, done_d;
  logic                    done_right_q, done_right_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic            rise_tick, fall_tick, wrap;
  logic [BitW-1:0] slot_pos;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    sck_d        = sck_q;
    ws_d         = ws_q;
    shift_d      = shift_q;
    done_d       = 1'b0;
    done_right_d = done_right_q;

    rise_tick = (state_q != StIdle) && (div_q == RiseCnt);
    fall_tick = (state_q != StIdle) && (div_q == FallCnt);
    wrap      = fall_tick && (bit_q == LastBit);
    slot_pos  = (bit_q >= SlotW) ? bit_q - SlotW : bit_q;

    if (state_q != StIdle) begin
      div_d = fall_tick ? '0 : div_q + DivW'(1);
      sck_d = (div_d >= HalfCnt);
    end

    if (fall_tick) begin
      bit_d = (bit_q == LastBit) ? '0 : bit_q + BitW'(1);
      ws_d  = (bit_d >= SlotW);
    end

    // One-bit I2S delay: slot bit 0 is skipped, bits 1..SAMPLE_WIDTH carry the sample.
    if (rise_tick && (slot_pos >= BitW'(1)) && (slot_pos <= SampW)) begin
      shift_d = {shift_q[SAMPLE_WIDTH-2:0], sd_in};
      if (slot_pos == SampW) begin
        done_d       = (state_q == StRun) || (state_q == StStop);
        done_right_d = ws_q;
      end
    end

    unique case (state_q)
      StIdle: if (enable_in) state_d = StSync;
      StSync: if (wrap) state_d = enable_in ? StRun : StIdle;
      StRun:  if (!enable_in) state_d = StStop;
      StStop: if (wrap) state_d = enable_in ? StRun : StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      div_d = '0;
      bit_d = '0;
      sck_d = 1'b0;
      ws_d  = 1'b0;
    end
  end

  // Output register: a completed sample loads if the slot is free or being accepted now.
  always_comb begin
    sample_d  = sample_q;
    right_d   = right_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (valid_q && sample_ready_in) valid_d = 1'b0;

    if (done_q) begin
      if (!valid_q || sample_ready_in) begin
        sample_d = shift_q;
        right_d  = done_right_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      div_q        <= '0;
      bit_q        <= '0;
      sck_q        <= 1'b0;
      ws_q         <= 1'b0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      done_right_q <= 1'b0;
      sample_q     <= '0;
      right_q      <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      sck_q        <= sck_d;
      ws_q         <= ws_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      done_right_q <= done_right_d;
      sample_q     <= sample_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sck_out          = sck_q;
  assign ws_out           = ws_q;
  assign sample_out       = sample_q;
  assign sample_right_out = right_q;
  assign sample_valid_out = valid_q;
  assign overrun_out      = overrun_q;
  assign active_out       = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// Directed bench for i2s_rx_sequencer with a microphone model that follows SCK/WS.
module tb_i2s_rx_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        enable_in = 1'b0;
  logic        sd_in = 1'b0;
  logic        sample_ready_in = 1'b0;
  logic        sck_out, ws_out, sample_right_out, sample_valid_out, overrun_out, active_out;
  logic [23:0] sample_out;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;

  logic [23:0] mic_left  = 24'hA5A5A5;
  logic [23:0] mic_right = 24'h5A5A5A;
  logic [23:0] mic_word;
  int          mic_p = 0;
  logic        mic_ws = 1'b0;

  i2s_rx_sequencer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .enable_in        (enable_in),
    .sd_in            (sd_in),
    .sck_out          (sck_out),
    .ws_out           (ws_out),
    .sample_out       (sample_out),
    .sample_right_out (sample_right_out),
    .sample_valid_out (sample_valid_out),
    .sample_ready_in  (sample_ready_in),
    .overrun_out      (overrun_out),
    .active_out       (active_out)
  );

  initial forever #5 clk_in = ~clk_in;

  // Microphone: MSB one SCK after each WS change, data shifted out on SCK falling edges.
  initial forever begin
    @(negedge sck_out or negedge active_out);
    #1;
    if (!active_out) begin
      mic_p  = 0;
      mic_ws = 1'b0;
    end else begin
      if (ws_out != mic_ws) mic_p = 0;
      else mic_p++;
      mic_ws = ws_out;
    end
    mic_word = mic_ws ? mic_right : mic_left;
    sd_in = (mic_p >= 1 && mic_p <= 24) ? mic_word[24 - mic_p] : 1'b0;
  end

  task automatic step();
    @(negedge clk_in);
    k++;
  endtask

  task automatic test_reset();
    logic moved = 1'b0;
    rst_n_in = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (sck_out !== 1'b0 || ws_out !== 1'b0) moved = 1'b1;
    end
    n_vec++; if (moved !== 1'b0) begin n_err++; $display("FAIL rst_static: clocks moved %b, want 0", moved); end
    n_vec++; if (sample_out !== 24'h0) begin n_err++; $display("FAIL rst_sample: got %h want 000000", sample_out); end
    n_vec++; if (sample_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", sample_valid_out); end
    n_vec++; if (sample_right_out !== 1'b0) begin n_err++; $display("FAIL rst_right: got %b want 0", sample_right_out); end
    n_vec++; if (overrun_out !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun_out); end
    n_vec++; if (active_out !== 1'b0) begin n_err++; $display("FAIL rst_active: got %b want 0", active_out); end
    rst_n_in = 1'b1;
    for (int i = 0; i < 50; i++) @(negedge clk_in);
    n_vec++; if (active_out !== 1'b0 || sck_out !== 1'b0) begin
      n_err++; $display("FAIL idle_hold: active %b sck %b, want 0 0", active_out, sck_out);
    end
  endtask

  task automatic test_stream();
    int   sck_r[2] = '{0, 0};
    int   ws_r[2]  = '{0, 0};
    int   ws_f     = 0;
    int   n_sck    = 0;
    int   n_ws     = 0;
    logic early    = 1'b0;
    logic p_sck    = 1'b0;
    logic p_ws     = 1'b0;
    k = 0;
    sample_ready_in = 1'b1;
    enable_in = 1'b1;
    while (k < 5000) begin
      step();
      if (sck_out && !p_sck && n_sck < 2) begin sck_r[n_sck] = k; n_sck++; end
      if (ws_out && !p_ws && n_ws < 2) begin ws_r[n_ws] = k; n_ws++; end
      if (!ws_out && p_ws && ws_f == 0) ws_f = k;
      p_sck = sck_out;
      p_ws  = ws_out;
      if (k < 2834 && sample_valid_out) early = 1'b1;
      if (k == 2834 || k == 4882) begin
        n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'hA5A5A5 || sample_right_out !== 1'b0) begin
          n_err++; $display("FAIL left_sample@%0d: v%b %h r%b, want v1 a5a5a5 r0", k, sample_valid_out, sample_out, sample_right_out);
        end
      end
      if (k == 2835) begin
        n_vec++; if (sample_valid_out !== 1'b0) begin n_err++; $display("FAIL valid_clear: got %b want 0", sample_valid_out); end
      end
      if (k == 3858) begin
        n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'h5A5A5A || sample_right_out !== 1'b1) begin
          n_err++; $display("FAIL right_sample: v%b %h r%b, want v1 5a5a5a r1", sample_valid_out, sample_out, sample_right_out);
        end
      end
    end
    n_vec++; if (sck_r[0] !== 17) begin n_err++; $display("FAIL first_sck_rise: got %0d want 17", sck_r[0]); end
    n_vec++; if (sck_r[1] - sck_r[0] !== 32) begin n_err++; $display("FAIL sck_period: got %0d want 32", sck_r[1] - sck_r[0]); end
    n_vec++; if (ws_r[1] - ws_r[0] !== 2048) begin n_err++; $display("FAIL ws_period: got %0d want 2048", ws_r[1] - ws_r[0]); end
    n_vec++; if (ws_f - ws_r[0] !== 1024) begin n_err++; $display("FAIL ws_high: got %0d want 1024", ws_f - ws_r[0]); end
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL sync_discard: valid seen %b want 0", early); end
  endtask

  task automatic test_overrun();
    int pulses = 0;
    sample_ready_in = 1'b0;
    while (k < 7001) begin
      step();
      if (overrun_out) pulses++;
      if (k == 5906) begin
        n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'h5A5A5A) begin
          n_err++; $display("FAIL ovr_first: v%b %h, want v1 5a5a5a", sample_valid_out, sample_out);
        end
      end
      if (k == 6930) begin
        n_vec++; if (overrun_out !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", overrun_out); end
        n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'h5A5A5A || sample_right_out !== 1'b1) begin
          n_err++; $display("FAIL ovr_hold: v%b %h r%b, want v1 5a5a5a r1", sample_valid_out, sample_out, sample_right_out);
        end
      end
      if (k == 7000) sample_ready_in = 1'b1;
    end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", pulses); end
    n_vec++; if (sample_valid_out !== 1'b0) begin n_err++; $display("FAIL ovr_accept: valid %b want 0", sample_valid_out); end
  endtask

  task automatic test_back_to_back();
    logic dropped = 1'b0;
    logic ovr     = 1'b0;
    sample_ready_in = 1'b0;
    while (k < 8979) begin
      step();
      if (overrun_out) ovr = 1'b1;
      if (k == 7954) begin
        n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'h5A5A5A) begin
          n_err++; $display("FAIL b2b_first: v%b %h, want v1 5a5a5a", sample_valid_out, sample_out);
        end
      end
      if (k > 7954 && k <= 8978 && !sample_valid_out) dropped = 1'b1;
      if (k == 8977) sample_ready_in = 1'b1;
      if (k == 8978) begin
        n_vec++; if (sample_out !== 24'hA5A5A5 || sample_right_out !== 1'b0) begin
          n_err++; $display("FAIL b2b_load: %h r%b, want a5a5a5 r0", sample_out, sample_right_out);
        end
      end
    end
    n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL b2b_valid_gap: got %b want 0", dropped); end
    n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", ovr); end
    n_vec++; if (sample_valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_accept: valid %b want 0", sample_valid_out); end
  endtask

  task automatic test_disable();
    logic early = 1'b0;
    while (k < 15234) begin
      step();
      if (k == 10500) enable_in = 1'b0;
      if (k == 11026) begin
        n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'hA5A5A5) begin
          n_err++; $display("FAIL dis_left: v%b %h, want v1 a5a5a5", sample_valid_out, sample_out);
        end
      end
      if (k == 12050) begin
        n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'h5A5A5A || sample_right_out !== 1'b1) begin
          n_err++; $display("FAIL dis_right: v%b %h r%b, want v1 5a5a5a r1", sample_valid_out, sample_out, sample_right_out);
        end
      end
      if (k == 12288) begin
        n_vec++; if (active_out !== 1'b1) begin n_err++; $display("FAIL dis_stop_active: got %b want 1", active_out); end
      end
      if (k == 12289) begin
        n_vec++; if (active_out !== 1'b0 || sck_out !== 1'b0 || ws_out !== 1'b0) begin
          n_err++; $display("FAIL dis_idle: active %b sck %b ws %b, want 0 0 0", active_out, sck_out, ws_out);
        end
      end
      if (k == 12400) enable_in = 1'b1;
      if (k > 12050 && k < 15234 && sample_valid_out) early = 1'b1;
    end
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL resync_discard: valid seen %b want 0", early); end
    n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'hA5A5A5 || sample_right_out !== 1'b0) begin
      n_err++; $display("FAIL resync_left: v%b %h r%b, want v1 a5a5a5 r0", sample_valid_out, sample_out, sample_right_out);
    end
  endtask

  task automatic test_reset_mid();
    logic early = 1'b0;
    while (k < 16000) step();
    n_vec++; if (ws_out !== 1'b1) begin n_err++; $display("FAIL mid_pre_ws: got %b want 1", ws_out); end
    #2 rst_n_in = 1'b0;
    #1;
    n_vec++; if (ws_out !== 1'b0 || sck_out !== 1'b0 || active_out !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_clk: ws %b sck %b active %b, want 0 0 0", ws_out, sck_out, active_out);
    end
    n_vec++; if (sample_out !== 24'h0 || sample_valid_out !== 1'b0 || sample_right_out !== 1'b0 || overrun_out !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_out: %h v%b r%b o%b, want 000000 0 0 0", sample_out, sample_valid_out, sample_right_out, overrun_out);
    end
    #1 rst_n_in = 1'b1;
    while (k < 18834) begin
      step();
      if (k < 18834 && sample_valid_out) early = 1'b1;
    end
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL mid_partial: valid seen %b want 0", early); end
    n_vec++; if (sample_valid_out !== 1'b1 || sample_out !== 24'hA5A5A5 || sample_right_out !== 1'b0) begin
      n_err++; $display("FAIL mid_resume: v%b %h r%b, want v1 a5a5a5 r0", sample_valid_out, sample_out, sample_right_out);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overrun();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx_sequencer.md
Name: i2s_rx_sequencer

Overview:
Master-mode I2S receive sequencer for the microphone front end. Generates SCK and WS from clk_in, deserialises the serial data line into left and right PCM samples, and hands each sample to the downstream audio pipeline over a valid/ready handshake. Enable and disable are frame-aligned, and the first frame after enable is discarded while the microphone settles.

Parameters:
CLK_DIV, 32, clk_in cycles per SCK period; even, >=4 (100 MHz / 32 = 3.125 MHz SCK)
SLOT_WIDTH, 32, SCK periods per channel slot; a frame is 2*SLOT_WIDTH SCK periods
SAMPLE_WIDTH, 24, bits captured per slot, MSB first; must be <= SLOT_WIDTH-1

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
enable_in  input  1  level; 1 = run capture, 0 = stop at the next frame boundary
sd_in  input  1  I2S serial data from the microphone (pre-synchronised)
sck_out  output  1  I2S bit clock
ws_out  output  1  I2S word select; 0 = left slot, 1 = right slot
sample_out  output  SAMPLE_WIDTH  captured sample, two's complement
sample_right_out  output  1  channel of sample_out (1 = right)
sample_valid_out  output  1  sample_out/sample_right_out hold valid data
sample_ready_in  input  1  consumer accepts the sample when valid && ready
overrun_out  output  1  one-cycle pulse: a completed sample was dropped
active_out  output  1  high in SYNC, RUN or STOP

Behaviour:
- Reset (async, rst_n_in=0): state IDLE, div_cnt=0, bit_cnt=0. sck_out=0, ws_out=0, sample_out=0, sample_right_out=0, sample_valid_out=0, overrun_out=0, active_out=0.
- div_cnt counts 0..CLK_DIV-1 in any non-IDLE state. sck_out is registered: 0 while div_cnt < CLK_DIV/2, 1 otherwise.
- Rise tick: div_cnt == CLK_DIV/2-1. sd_in is sampled on the clk_in edge that raises sck_out.
- Fall tick: div_cnt == CLK_DIV-1. bit_cnt advances mod 2*SLOT_WIDTH, and ws_out <= (next bit_cnt >= SLOT_WIDTH), so ws_out changes with the SCK falling edge.
- Slot position p = bit_cnt mod SLOT_WIDTH. Bits are captured at the rise ticks of p = 1..SAMPLE_WIDTH (I2S one-bit delay), shifting MSB first.
- Channel of the capture = ws_out during capture.
- Sample complete: the rise tick at p = SAMPLE_WIDTH. Remaining slot bits are ignored.
- State machine:
  - IDLE: clocks held low, counters at 0. enable_in=1 -> SYNC; the first rise tick follows CLK_DIV/2 cycles later.
  - SYNC: clocks run, captures discarded. At the bit_cnt wrap 2*SLOT_WIDTH-1 -> 0, go to RUN.
  - RUN: deliver samples. If enable_in=0 is seen at any time, go to STOP.
  - STOP: clocks and capture continue until the bit_cnt wrap, then IDLE with div_cnt, bit_cnt, sck_out and ws_out forced to 0.
  - STOP with enable_in=1 again at the wrap -> RUN (no resync).
  - enable_in=0 during SYNC -> IDLE at the wrap.
- Handshake:
  - A completed sample loads the output register one cycle after its completing rise tick, and sample_valid_out goes 1.
  - Data is stable while valid && !ready. Valid clears on the cycle after acceptance unless a new sample loads on that same edge.
  - Sample completes while valid=1 and ready=0: the new sample is dropped, the held sample is retained, and overrun_out pulses 1 cycle.
  - Sample completes on the same edge as acceptance: the new sample loads, valid stays 1, no overrun.
- A pending sample stays valid after the return to IDLE until accepted.
- Reset mid-frame aborts immediately. No partial sample is ever presented.
- Outputs are registered with no combinational input-to-output paths. Latency from the last data bit's SCK rise to sample_valid_out is 1 clk_in cycle.

Test Plan:
1. Reset with enable_in=0, hold 1000 cycles -> all outputs 0, sck_out and ws_out static 0.
2. Defaults, enable_in=1, ready tied 1, sd_in driven for left=24'hA5A5A5 and right=24'h5A5A5A each frame:
   - sck_out period 32 cycles, ws_out period 2048 cycles with 50% duty.
   - No valid during the first frame.
   - Then alternating samples: 24'hA5A5A5 (right=0) and 24'h5A5A5A (right=1), one per 1024 cycles.
3. Ready held 0 across two sample completions -> first sample held unchanged, overrun_out single pulse at the second completion. Ready=1 then accepts the first sample.
4. Ready asserted exactly on a completion edge -> the new sample loads, valid never drops, no overrun.
5. enable_in 1->0 mid left slot -> right sample still delivered, state IDLE at the frame wrap, sck_out=0, active_out=0. Re-enable -> one discarded SYNC frame before samples resume.
6. rst_n_in pulsed low asynchronously mid-capture (between clk edges) -> outputs 0 immediately, no partial sample after release.
